inst_prefetch: RTL and testbench

- Instruction prefetch buffer between the instruction ROM and cpu_core.
- Drives the ROM request/valid handshake with a sequential fetch PC.
- Stores returned {pc, inst} pairs in a small FIFO and presents them to the core in order.
- Supports a core redirect (branch/jump) that flushes the buffer and restarts fetch at a new PC.

---
 rtl/inst_prefetch.sv | 132 +++++++++++++
 tb/tb_inst_prefetch.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_prefetch.sv
// Instruction prefetch buffer between the instruction ROM and the core.
// Keeps one ROM request in flight and queues {pc, inst} pairs in order.
module inst_prefetch #(
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     rom_ce,
  output logic [63:0]              rom_addr,
  input  logic                     rom_valid,
  input  logic [31:0]              rom_inst,
  output logic                     core_valid,
  output logic [31:0]              core_inst,
  output logic [63:0]              core_pc,
  input  logic                     core_req,
  input  logic                     redirect,
  input  logic [63:0]              redirect_pc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    FLUSH
  } state_t;

  state_t          state;
  logic [63:0]     fetch_pc;
  logic [63:0]     fetch_inc;
  logic [63:0]     new_pc;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [CW-1:0]   count_next;
  logic            push;
  logic            pop;
  logic            can_issue;

  logic [63:0]     pc_mem   [DEPTH];
  logic [31:0]     inst_mem [DEPTH];

  // rom_ce is only high in WAIT, so it also qualifies the response
  assign push      = rom_ce & rom_valid & ~redirect;
  assign pop       = core_valid & core_req & ~redirect;
  assign fetch_inc = fetch_pc + 64'd4;
  assign new_pc    = redirect_pc & ~64'd3;

  always_comb begin
    count_next = count;
    if (push && !pop)
      count_next = count + CW'(1);
    else if (pop && !push)
      count_next = count - CW'(1);
  end

  assign can_issue  = count_next < CW'(DEPTH);
  assign core_valid = (count != '0);
  assign core_inst  = inst_mem[rd_ptr];
  assign core_pc    = pc_mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      rom_ce   <= 1'b0;
      rom_addr <= RESET_PC;
      fetch_pc <= RESET_PC;
    end else if (redirect) begin
      state    <= FLUSH;
      rom_ce   <= 1'b0;
      fetch_pc <= new_pc;
    end else begin
      unique case (state)
        IDLE: begin
          if (can_issue) begin
            rom_ce   <= 1'b1;
            rom_addr <= fetch_pc;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (rom_valid) begin
            fetch_pc <= fetch_inc;
            if (can_issue) begin
              rom_addr <= fetch_inc;
            end else begin
              rom_ce <= 1'b0;
              state  <= IDLE;
            end
          end
        end
        FLUSH: begin
          rom_ce <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          rom_ce <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
    end
  end

  // storage needs no reset; core_valid masks stale entries
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= rom_addr;
      inst_mem[wr_ptr] <= rom_inst;
    end
  end

endmodule

// File: tb/tb_inst_prefetch.sv
// Bench for inst_prefetch: ROM model with variable latency,
// in-order scoreboard of fetched {pc, inst} pairs.
module tb_inst_prefetch;

  localparam int          DEPTH    = 4;
  localparam logic [63:0] RESET_PC = 64'h0;
  localparam int          CW       = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst;
  logic          rom_ce;
  logic [63:0]   rom_addr;
  logic          rom_valid;
  logic [31:0]   rom_inst;
  logic          core_valid;
  logic [31:0]   core_inst;
  logic [63:0]   core_pc;
  logic          core_req;
  logic          redirect;
  logic [63:0]   redirect_pc;
  logic [CW-1:0] count;

  inst_prefetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .rom_ce(rom_ce), .rom_addr(rom_addr),
    .rom_valid(rom_valid), .rom_inst(rom_inst),
    .core_valid(core_valid), .core_inst(core_inst),
    .core_pc(core_pc), .core_req(core_req),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  int          pops = 0;
  int          exp_cnt = 0;
  logic [63:0] next_pc = RESET_PC;
  int          lat_fix = 1;
  int          lat_cur = 1;
  int          held = 0;

  function automatic logic [31:0] inst_of(input logic [63:0] a);
    return (a[33:2] * 32'h9E3779B1) ^ a[63:32] ^ 32'h1234_5678;
  endfunction

  // ROM: answers when the request has been held for lat_cur cycles
  assign rom_inst  = inst_of(rom_addr);
  assign rom_valid = rom_ce && (held + 1 >= lat_cur);

  always @(posedge clk) begin
    if (!rom_ce || rom_valid) begin
      held    <= 0;
      lat_cur <= (lat_fix != 0) ? lat_fix : int'($urandom_range(1, 3));
    end else begin
      held <= held + 1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: sequential fetch stream, restarted by redirect
  always @(negedge clk) begin
    bit pushed, popped;
    if (rst) begin
      chk("count", 64'(count), 64'(exp_cnt));
      chk("core_valid", 64'(core_valid), 64'(exp_cnt != 0));
      if (exp_cnt == DEPTH)
        chk("full_ce_low", 64'(rom_ce), 64'd0);
      if (rom_ce)
        chk("rom_addr", rom_addr, next_pc);
      if (redirect) begin
        sb.delete();
        exp_cnt = 0;
        next_pc = redirect_pc & ~64'd3;
      end else begin
        pushed = rom_ce && rom_valid;
        popped = (exp_cnt != 0) && core_req;
        if (pushed) begin
          sb.push_back({next_pc, inst_of(next_pc)});
          next_pc = next_pc + 64'd4;
        end
        exp_cnt = exp_cnt + int'(pushed) - int'(popped);
      end
    end
  end

  // monitor: every core handshake must match the scoreboard head
  always @(negedge clk) begin
    ent_t e;
    if (rst && core_valid && core_req && !redirect) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_empty: got pc %h want no entry", core_pc);
      end else begin
        e = sb.pop_front();
        chk("core_pc", core_pc, e.pc);
        chk("core_inst", 64'(core_inst), 64'(e.inst));
        pops++;
      end
    end
  end

  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst_ce", 64'(rom_ce), 64'd0);
    chk("rst_addr", rom_addr, RESET_PC);
    chk("rst_valid", 64'(core_valid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    sb.delete();
    exp_cnt = 0;
    next_pc = RESET_PC;
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int n;
    int p0;
    rst = 1'b1;
    core_req = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    #2;

    // startup latency and 1/cycle streaming
    lat_fix = 1;
    core_req = 1'b1;
    do_reset();
    step(1);
    chk("start_ce", 64'(rom_ce), 64'd1);
    chk("start_nvalid", 64'(core_valid), 64'd0);
    step(1);
    chk("start_valid", 64'(core_valid), 64'd1);
    chk("start_pc", core_pc, RESET_PC);
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk("stream_valid", 64'(core_valid), 64'd1);
      chk("stream_cnt_le1", 64'(count <= 1), 64'd1);
    end

    // fill to DEPTH without popping, then drain
    core_req = 1'b0;
    do_reset();
    step(12);
    chk("fill_count", 64'(count), 64'(DEPTH));
    chk("fill_ce", 64'(rom_ce), 64'd0);
    core_req = 1'b1;
    n = 0;
    while (!rom_ce && n < 4) begin
      step(1);
      n++;
    end
    chk("resume_ce", 64'(rom_ce), 64'd1);
    chk("resume_addr", rom_addr, RESET_PC + 64'd16);
    step(20);

    // 3-cycle ROM: one instruction every third cycle
    lat_fix = 3;
    core_req = 1'b1;
    do_reset();
    step(10);
    p0 = pops;
    step(30);
    chk("lat3_throughput", 64'(pops - p0), 64'd10);

    // redirect while a response is accepted and count=2
    lat_fix = 1;
    core_req = 1'b0;
    do_reset();
    n = 0;
    while (count != 2 && n < 20) begin
      step(1);
      n++;
    end
    chk("redir_pre_cnt", 64'(count), 64'd2);
    chk("redir_pre_ce", 64'(rom_ce), 64'd1);
    redirect = 1'b1;
    redirect_pc = 64'h1003;
    step(1);
    redirect = 1'b0;
    chk("redir_cnt0", 64'(count), 64'd0);
    chk("redir_ce0", 64'(rom_ce), 64'd0);
    step(1);
    chk("redir_bubble", 64'(rom_ce), 64'd0);
    core_req = 1'b1;
    step(1);
    chk("redir_ce1", 64'(rom_ce), 64'd1);
    chk("redir_addr", rom_addr, 64'h1000);
    step(1);
    chk("redir_core_pc", core_pc, 64'h1000);

    // fetch address wraps past 2^64
    redirect = 1'b1;
    redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    step(1);
    redirect = 1'b0;
    step(2);
    chk("wrap_top", rom_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    step(1);
    chk("wrap_addr0", rom_addr, 64'h0);
    chk("wrap_ce", 64'(rom_ce), 64'd1);
    chk("wrap_head_top", core_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    step(1);
    chk("wrap_head0", core_pc, 64'h0);

    // random traffic
    lat_fix = 0;
    for (int i = 0; i < 3000; i++) begin
      core_req = ($urandom_range(0, 3) != 0);
      redirect = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 3) == 0)
        redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
      else
        redirect_pc = {$urandom, $urandom};
      step(1);
    end
    redirect = 1'b0;

    // async reset in the middle of a pending request
    lat_fix = 3;
    core_req = 1'b0;
    step(1);
    n = 0;
    while (!(count == CW'(DEPTH - 1) && rom_ce) && n < 60) begin
      step(1);
      n++;
    end
    chk("pre_rst_cnt", 64'(count), 64'(DEPTH - 1));
    do_reset();
    step(1);
    chk("post_rst_ce", 64'(rom_ce), 64'd1);
    chk("post_rst_addr", rom_addr, RESET_PC);
    core_req = 1'b1;
    step(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
